// File: rtl/flag_pkg.sv
// rtl/flag_pkg.sv - condition codes, flag bit indices and FSM states for the flag/branch unit
package flag_pkg;

  localparam logic [2:0] COND_NE     = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_GT     = 3'b010;
  localparam logic [2:0] COND_LT     = 3'b011;
  localparam logic [2:0] COND_GTE    = 3'b100;
  localparam logic [2:0] COND_LTE    = 3'b101;
  localparam logic [2:0] COND_OVFL   = 3'b110;
  localparam logic [2:0] COND_UNCOND = 3'b111;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational branch condition evaluation against {N,Z,V}
module cond_eval
  import flag_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic n, z, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NE:     taken = ~z;
      COND_EQ:     taken = z;
      COND_GT:     taken = ~z & ~n;
      COND_LT:     taken = n;
      COND_GTE:    taken = z | ~n;
      COND_LTE:    taken = n | z;
      COND_OVFL:   taken = v;
      COND_UNCOND: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// rtl/flag_branch_unit.sv - flag register, flag RAW stall FSM and registered branch resolution
module flag_branch_unit
  import flag_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [2:0]        ex_flag_we,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_n,
  input  logic              ex_v,
  input  logic              flush,
  input  logic              id_br_valid,
  input  logic [2:0]        id_br_cond,
  output logic              id_br_ready,
  output logic              br_resolve_valid,
  output logic              br_taken,
  output logic [2:0]        flags_q
);

  state_t     state;
  logic       hazard;
  logic       cond_taken;
  logic [2:0] flags_new;

  assign hazard      = ex_valid & (|ex_flag_we);
  assign id_br_ready = id_br_valid & ~hazard & ~flush;

  always_comb begin
    flags_new         = 3'b000;
    flags_new[FLAG_N] = ex_n;
    flags_new[FLAG_Z] = ~(|ex_result);
    flags_new[FLAG_V] = ex_v;
  end

  // Accept only happens when no flag write is in flight, so flags_q is current here.
  cond_eval u_cond_eval (
    .cond  (id_br_cond),
    .flags (flags_q),
    .taken (cond_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      flags_q          <= 3'b000;
      br_resolve_valid <= 1'b0;
      br_taken         <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ex_valid && ex_flag_we[i]) flags_q[i] <= flags_new[i];
      end

      br_resolve_valid <= id_br_ready;
      if (id_br_ready) br_taken <= cond_taken;

      case (state)
        ST_IDLE: if (id_br_valid && hazard && !flush) state <= ST_WAIT;
        ST_WAIT: if (flush || !id_br_valid || id_br_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// tb/tb_flag_branch_unit.sv - directed self-checking bench for flag_branch_unit
module tb_flag_branch_unit;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [2:0]  ex_flag_we;
  logic [15:0] ex_result;
  logic        ex_n;
  logic        ex_v;
  logic        flush;
  logic        id_br_valid;
  logic [2:0]  id_br_cond;
  logic        id_br_ready;
  logic        br_resolve_valid;
  logic        br_taken;
  logic [2:0]  flags_q;

  int errors = 0;
  int checks = 0;

  flag_branch_unit #(.DATA_W(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_valid         (ex_valid),
    .ex_flag_we       (ex_flag_we),
    .ex_result        (ex_result),
    .ex_n             (ex_n),
    .ex_v             (ex_v),
    .flush            (flush),
    .id_br_valid      (id_br_valid),
    .id_br_cond       (id_br_cond),
    .id_br_ready      (id_br_ready),
    .br_resolve_valid (br_resolve_valid),
    .br_taken         (br_taken),
    .flags_q          (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ex_valid   = 1'b0;
    ex_flag_we = 3'b000;
    ex_result  = 16'h0000;
    ex_n       = 1'b0;
    ex_v       = 1'b0;
  endtask

  task automatic ex_op(input logic [2:0] we, input logic [15:0] res, input logic n, input logic v);
    ex_valid   = 1'b1;
    ex_flag_we = we;
    ex_result  = res;
    ex_n       = n;
    ex_v       = v;
  endtask

  // Reference condition table, {N,Z,V} order.
  function automatic logic exp_taken(input logic [2:0] c, input logic [2:0] f);
    logic n, z, v;
    n = f[2];
    z = f[1];
    v = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    id_br_valid = 1'b0;
    id_br_cond  = 3'b000;
    ex_idle();
    step();
    step();
    check("reset_flags", {5'b0, flags_q}, 8'h00);
    check("reset_resolve", {7'b0, br_resolve_valid}, 8'h00);
    check("reset_taken", {7'b0, br_taken}, 8'h00);
    rst_n = 1'b1;
    step();
    check("idle_flags", {5'b0, flags_q}, 8'h00);
    check("idle_resolve", {7'b0, br_resolve_valid}, 8'h00);

    // ADD 0x7FFF+1 saturates with V=1
    ex_op(3'b111, 16'h7FFF, 1'b0, 1'b1);
    step();
    check("add_flags", {5'b0, flags_q}, 8'h01);
    ex_idle();
    id_br_valid = 1'b1;
    id_br_cond  = 3'b110;
    #1;
    check("ovfl_ready", {7'b0, id_br_ready}, 8'h01);
    step();
    check("ovfl_resolve", {7'b0, br_resolve_valid}, 8'h01);
    check("ovfl_taken", {7'b0, br_taken}, 8'h01);
    id_br_valid = 1'b0;
    step();
    check("resolve_drops", {7'b0, br_resolve_valid}, 8'h00);
    check("taken_holds", {7'b0, br_taken}, 8'h01);

    // SUB producing zero in the same cycle as branch EQ: one stall cycle
    ex_op(3'b111, 16'h0000, 1'b0, 1'b0);
    id_br_valid = 1'b1;
    id_br_cond  = 3'b001;
    #1;
    check("raw_stall_ready", {7'b0, id_br_ready}, 8'h00);
    step();
    check("raw_flags", {5'b0, flags_q}, 8'h02);
    check("raw_no_resolve", {7'b0, br_resolve_valid}, 8'h00);
    ex_idle();
    #1;
    check("raw_accept_ready", {7'b0, id_br_ready}, 8'h01);
    step();
    check("raw_resolve", {7'b0, br_resolve_valid}, 8'h01);
    check("raw_taken", {7'b0, br_taken}, 8'h01);
    id_br_valid = 1'b0;

    // Logic op clears Z only, then PADDSB with zero result writes nothing
    ex_op(3'b010, 16'h0005, 1'b1, 1'b1);
    step();
    check("logic_flags", {5'b0, flags_q}, 8'h00);
    ex_op(3'b000, 16'h0000, 1'b1, 1'b1);
    id_br_valid = 1'b1;
    id_br_cond  = 3'b001;
    #1;
    check("paddsb_no_stall", {7'b0, id_br_ready}, 8'h01);
    step();
    check("paddsb_resolve", {7'b0, br_resolve_valid}, 8'h01);
    check("paddsb_taken", {7'b0, br_taken}, 8'h00);
    check("paddsb_flags", {5'b0, flags_q}, 8'h00);
    id_br_valid = 1'b0;
    ex_idle();
    step();

    // Full sweep: every flag combination against every condition
    for (int f = 0; f < 8; f++) begin
      logic [2:0] fv;
      fv = f[2:0];
      ex_op(3'b111, fv[1] ? 16'h0000 : 16'h0100, fv[2], fv[0]);
      step();
      ex_idle();
      check($sformatf("sweep_flags_%0d", f), {5'b0, flags_q}, {5'b0, fv});
      for (int c = 0; c < 8; c++) begin
        logic [2:0] cv;
        cv = c[2:0];
        id_br_valid = 1'b1;
        id_br_cond  = cv;
        step();
        check($sformatf("sweep_valid_f%0d_c%0d", f, c), {7'b0, br_resolve_valid}, 8'h01);
        check($sformatf("sweep_taken_f%0d_c%0d", f, c), {7'b0, br_taken}, {7'b0, exp_taken(cv, fv)});
      end
      id_br_valid = 1'b0;
    end
    step();

    // Flush on the accept cycle: no resolve, flag write still lands
    ex_op(3'b111, 16'h0000, 1'b0, 1'b0);
    step();
    ex_idle();
    step();
    ex_op(3'b000, 16'h0001, 1'b0, 1'b0);
    flush       = 1'b1;
    id_br_valid = 1'b1;
    id_br_cond  = 3'b111;
    #1;
    check("flush_accept_ready", {7'b0, id_br_ready}, 8'h00);
    step();
    check("flush_accept_resolve", {7'b0, br_resolve_valid}, 8'h00);
    ex_op(3'b101, 16'h0001, 1'b1, 1'b1);
    id_br_valid = 1'b0;
    step();
    check("flush_flag_write", {5'b0, flags_q}, 8'h07);
    flush = 1'b0;
    ex_idle();

    // Branch stalled into WAIT, then flushed
    ex_op(3'b111, 16'h0001, 1'b0, 1'b0);
    id_br_valid = 1'b1;
    id_br_cond  = 3'b111;
    step();
    check("wait_no_resolve", {7'b0, br_resolve_valid}, 8'h00);
    ex_idle();
    flush = 1'b1;
    #1;
    check("wait_flush_ready", {7'b0, id_br_ready}, 8'h00);
    step();
    check("wait_flush_resolve", {7'b0, br_resolve_valid}, 8'h00);
    flush       = 1'b0;
    id_br_valid = 1'b0;
    step();
    check("post_flush_resolve", {7'b0, br_resolve_valid}, 8'h00);

    // Async reset while waiting
    ex_op(3'b111, 16'h0003, 1'b1, 1'b1);
    id_br_valid = 1'b1;
    id_br_cond  = 3'b111;
    step();
    check("pre_rst_flags", {5'b0, flags_q}, 8'h05);
    ex_idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_flags", {5'b0, flags_q}, 8'h00);
    check("async_rst_resolve", {7'b0, br_resolve_valid}, 8'h00);
    id_br_valid = 1'b0;
    step();
    rst_n = 1'b1;
    id_br_valid = 1'b1;
    id_br_cond  = 3'b000;
    #1;
    check("post_rst_ready", {7'b0, id_br_ready}, 8'h01);
    step();
    check("post_rst_resolve", {7'b0, br_resolve_valid}, 8'h01);
    check("post_rst_taken_ne", {7'b0, br_taken}, 8'h01);
    id_br_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
